regfile_wb: RTL and testbench

- Parametrised Y86-64 write-back stage and register file with two write ports (E and M) and two read ports (A and B).
- Derives dstE/dstM from icode/cnd/rA/rB and commits on the rising clock edge under a valid/stall handshake.
- Provides a sticky halt flag and a retired-instruction counter.
- Sits between memory stage and decode stage; decode reads valA/valB from it.

---
 rtl/y86_pkg.sv | 22 ++
 rtl/wb_dst_decode.sv | 32 +++
 rtl/regfile_wb.sv | 94 +++++++++
 tb/tb_regfile_wb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register ids and default datapath width.
package y86_pkg;

  localparam int unsigned DATA_W_DEF = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/wb_dst_decode.sv
// Write-back destination decode: icode/cnd/rA/rB -> E and M destination register ids.
// Purely combinational so the hazard unit can share it.
module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic       cnd_i,
  input  logic [3:0] ra_i,
  input  logic [3:0] rb_i,
  output logic [3:0] dst_e_o,
  output logic [3:0] dst_m_o
);

  always_comb begin
    dst_e_o = RNONE;
    dst_m_o = RNONE;
    case (icode_i)
      IRRMOVQ: begin
        // cmovXX that fails its condition writes nothing
        if (cnd_i) dst_e_o = rb_i;
      end
      IIRMOVQ, IOPQ:               dst_e_o = rb_i;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e_o = RRSP;
      default: ;
    endcase
    case (icode_i)
      IMRMOVQ, IPOPQ: dst_m_o = ra_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_wb.sv
// Y86-64 write-back stage and register file: two write ports (E, M), two read ports (A, B),
// sticky halt and retire counter. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_wb
  import y86_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       NREG      = 15,
  parameter logic [DATA_W-1:0] RSP_RESET = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              halted_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic              commit;
  logic              wr_e;
  logic              wr_m;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  wb_dst_decode u_dst_decode (
    .icode_i (icode),
    .cnd_i   (cnd),
    .ra_i    (rA),
    .rb_i    (rB),
    .dst_e_o (dstE),
    .dst_m_o (dstM)
  );

  assign commit = wb_valid & ~wb_stall & ~halted_q;
  // Ids past the implemented file (other than RNONE) are silently dropped
  assign wr_e   = commit && (dstE != RNONE) && (32'(dstE) < NREG);
  assign wr_m   = commit && (dstM != RNONE) && (32'(dstM) < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? RSP_RESET : '0;
      end
      halted_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else if (commit) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      if (icode == IHALT) halted_q <= 1'b1;
      if (wr_e) regs_q[dstE] <= valE;
      // M port is written last so it wins when both target the same register
      if (wr_m) regs_q[dstM] <= valM;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (32'(srcA) < NREG) rd_a = regs_q[srcA];
    if (32'(srcB) < NREG) rd_b = regs_q[srcB];
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (wr_m && (srcA == dstM))      valA = valM;
    else if (wr_e && (srcA == dstE)) valA = valE;
    if (wr_m && (srcB == dstM))      valB = valM;
    else if (wr_e && (srcB == dstE)) valB = valE;
  end
`else
  assign valA = rd_a;
  assign valB = rd_b;
`endif

  assign halted     = halted_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a reference model pushes expected register contents into a
// scoreboard queue as each instruction is driven; entries are popped and checked after the edge.
module tb_regfile_wb;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_stall = 1'b0;
  logic [3:0]    icode = 4'h1;
  logic [3:0]    rA = 4'hF;
  logic [3:0]    rB = 4'hF;
  logic          cnd = 1'b0;
  logic [63:0]   valE = '0;
  logic [63:0]   valM = '0;
  logic [3:0]    srcA = '0;
  logic [3:0]    srcB = '0;
  logic [63:0]   valA;
  logic [63:0]   valB;
  logic [3:0]    dstE;
  logic [3:0]    dstM;
  logic          halted;
  logic [CW-1:0] retire_cnt;

  regfile_wb #(
    .DATA_W    (64),
    .NREG      (15),
    .RSP_RESET (64'h100),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_stall   (wb_stall),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .cnd        (cnd),
    .valE       (valE),
    .valM       (valM),
    .srcA       (srcA),
    .srcB       (srcB),
    .valA       (valA),
    .valB       (valB),
    .dstE       (dstE),
    .dstM       (dstM),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] val;
  } sb_entry_t;

  sb_entry_t     sb_q[$];
  logic [63:0]   m_regs [15];
  logic          m_halted;
  logic [CW-1:0] m_cnt;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic c,
                                        input logic [3:0] rb);
    case (ic)
      4'd2:                    return c ? rb : 4'hF;
      4'd3, 4'd6:              return rb;
      4'd8, 4'd9, 4'd10, 4'd11: return 4'd4;
      default:                 return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'd5 || ic == 4'd11) ? ra : 4'hF;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'h100 : 64'h0;
    m_halted = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic expect_reg(input logic [3:0] id);
    sb_entry_t e;
    e.id  = id;
    e.val = (id < 4'd15) ? m_regs[id] : 64'h0;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      srcA = e.id;
      srcB = e.id;
      #1;
      check($sformatf("valA[r%0d]", e.id), valA, e.val);
      check($sformatf("valB[r%0d]", e.id), valB, e.val);
    end
  endtask

  task automatic check_status();
    check("halted", 64'(halted), 64'(m_halted));
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
  endtask

  // Drive one write-back slot for a cycle, update the model, check after the edge
  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic valid);
    logic [3:0] de;
    logic [3:0] dm;
    icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
    wb_valid = valid;
    wb_stall = 1'b0;
    de = m_dste(ic, c, rb);
    dm = m_dstm(ic, ra);
    #1;
    check("dstE", 64'(dstE), 64'(de));
    check("dstM", 64'(dstM), 64'(dm));
    if (valid && !m_halted) begin
      m_cnt = m_cnt + 1'b1;
      if (ic == 4'd0) m_halted = 1'b1;
      if (de != 4'hF) m_regs[de] = ve;
      if (dm != 4'hF) m_regs[dm] = vm;
    end
    expect_reg(ra);
    expect_reg(rb);
    expect_reg(4'd4);
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    drain();
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    m_reset();
    #12;
    expect_reg(4'd4);
    expect_reg(4'd0);
    expect_reg(4'd15);
    drain();
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(4'd3, 4'hF, 4'd2, 1'b0, 64'h1234, 64'h0, 1'b1);        // irmovq -> r2
    drive(4'd2, 4'd0, 4'd3, 1'b0, 64'hFF, 64'h0, 1'b1);          // cmov not taken
    drive(4'd2, 4'd0, 4'd3, 1'b1, 64'hFF, 64'h0, 1'b1);          // cmov taken
    drive(4'd11, 4'd4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);     // popq %rsp: M wins
    drive(4'd11, 4'd1, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);     // popq %rcx
    drive(4'd5, 4'd9, 4'd2, 1'b0, 64'h0, 64'h5A5A, 1'b1);        // mrmovq -> r9

    // OPq held by stall for three cycles
    icode = 4'd6; rA = 4'd1; rB = 4'd7; valE = 64'h55; wb_valid = 1'b1; wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      expect_reg(4'd7);
      drain();
      check_status();
    end
    drive(4'd6, 4'd1, 4'd7, 1'b0, 64'h55, 64'h0, 1'b1);

    drive(4'd12, 4'd8, 4'd8, 1'b1, 64'h77, 64'h66, 1'b1);        // invalid icode
    drive(4'd3, 4'hF, 4'd8, 1'b0, 64'h99, 64'h0, 1'b0);          // bubble

    // Same-cycle visibility of a commit on the read port
    icode = 4'd3; rA = 4'hF; rB = 4'd6; valE = 64'h9; wb_valid = 1'b1; srcA = 4'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass valA", valA, 64'h9);
`else
    check("no-bypass valA", valA, 64'h0);
`endif
    drive(4'd3, 4'hF, 4'd6, 1'b0, 64'h9, 64'h0, 1'b1);

    for (int k = 0; k < 10; k++) drive(4'd1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);

    drive(4'd0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b1);           // halt
    drive(4'd3, 4'hF, 4'd5, 1'b0, 64'h7, 64'h0, 1'b1);           // blocked after halt

    // Asynchronous reset in the middle of a cycle with a commit pending
    wb_valid = 1'b1; icode = 4'd3; rB = 4'd2; valE = 64'hBAD;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int i = 0; i < 15; i++) expect_reg(4'(i));
    drain();
    check_status();
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd3, 4'hF, 4'd2, 1'b0, 64'hC0DE, 64'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
